// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline.
// Holds the fetch state encoding, bubble encoding, PC increment and reset PC.
package mips_pipe_pkg;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t FETCH = 1'b0;
    localparam fetch_state_t DRAIN = 1'b1;

    localparam logic [31:0] NOP_INS          = 32'd0;
    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux for the fetch stage.
// Priority: jump, then branch, then hold, then sequential increment.
module fetch_pc_sel
    import mips_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              hold,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(PC_INC);
        if (jump) begin
            next_pc = jump_target;
        end else if (branch) begin
            next_pc = branch_target;
        end else if (hold) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, req/ready imem port and redirect handling.
// Optional one-entry stall buffer is enabled by defining FETCH_BUF_EN.
module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCBranchD,
    input  logic              JumpD,
    input  logic [ADDR_W-1:0] PCJumpD,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       InsF,
    output logic [ADDR_W-1:0] PCPlus4F,
    output logic              FetchBusy
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              hold;
    logic              buf_active;
    logic [31:0]       held_ins;

    assign redirect = JumpD | PCSrcD;
    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

    // In DRAIN the PC already points at the redirect target; only a new redirect moves it.
    assign hold = (state_q == DRAIN) | StallF | (!buf_active & !imem_ready);

    fetch_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .pc            (pc_q),
        .jump          (JumpD),
        .jump_target   (PCJumpD),
        .branch        (PCSrcD),
        .branch_target (PCBranchD),
        .hold          (hold),
        .next_pc       (next_pc)
    );

    always_comb begin
        pc_d         = next_pc;
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            FETCH: begin
                // The outstanding request must finish before the target can be issued.
                if (redirect && !buf_active && !imem_ready) begin
                    state_d      = DRAIN;
                    drain_addr_d = pc_q;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            state_q      <= FETCH;
            drain_addr_q <= RESET_PC;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            drain_addr_q <= drain_addr_d;
        end
    end

`ifdef FETCH_BUF_EN
    logic [31:0] buf_q, buf_d;
    logic        buf_v_q, buf_v_d;

    always_comb begin
        buf_d   = buf_q;
        buf_v_d = buf_v_q;
        if (redirect || !StallF) begin
            buf_v_d = 1'b0;
        end else if (state_q == FETCH && !buf_v_q && imem_ready) begin
            buf_v_d = 1'b1;
            buf_d   = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q   <= NOP_INS;
            buf_v_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            buf_v_q <= buf_v_d;
        end
    end

    assign buf_active = buf_v_q;
    assign held_ins   = buf_q;
`else
    assign buf_active = 1'b0;
    assign held_ins   = NOP_INS;
`endif

    // Outputs are forced to their reset values for as long as rst is low.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        InsF      = NOP_INS;
        PCPlus4F  = '0;
        FetchBusy = 1'b0;
        if (rst) begin
            PCPlus4F = pc_plus4;
            if (state_q == DRAIN) begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                FetchBusy = 1'b1;
            end else if (buf_active) begin
                InsF = held_ins;
            end else begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    InsF = imem_rdata;
                end else begin
                    FetchBusy = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Honours FETCH_BUF_EN to select the expected stall behaviour.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InsF;
    logic [31:0] PCPlus4F;
    logic        FetchBusy;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InsF       (InsF),
        .PCPlus4F   (PCPlus4F),
        .FetchBusy  (FetchBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Position 2 time units after the next rising edge, then callers drive and sample.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        StallF     = 1'b0;
        PCSrcD     = 1'b0;
        PCBranchD  = '0;
        JumpD      = 1'b0;
        PCJumpD    = '0;
        imem_ready = 1'b1;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_ins", InsF, 32'd0);
        check("rst_pcp4", PCPlus4F, 32'd0);
        check("rst_busy", {31'd0, FetchBusy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        StallF     = 1'b0;
        PCSrcD     = 1'b0;
        PCBranchD  = '0;
        JumpD      = 1'b0;
        PCJumpD    = '0;
        imem_ready = 1'b1;
        #2;
        do_reset();

        // 1: sequential fetch with zero-wait memory
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                next_cycle();
                #1;
            end
            check("seq_addr", imem_addr, 32'(i * 4));
            check("seq_pcp4", PCPlus4F, 32'(i * 4 + 4));
            check("seq_busy", {31'd0, FetchBusy}, 32'd0);
            check("seq_ins", InsF, mem_word(32'(i * 4)));
        end

        // 2: two wait cycles at address 8
        next_cycle();
        do_reset();
        next_cycle();
        next_cycle();
        imem_ready = 1'b0;
        #1;
        check("wait1_addr", imem_addr, 32'h8);
        check("wait1_ins", InsF, 32'd0);
        check("wait1_busy", {31'd0, FetchBusy}, 32'd1);
        next_cycle();
        #1;
        check("wait2_addr", imem_addr, 32'h8);
        check("wait2_busy", {31'd0, FetchBusy}, 32'd1);
        next_cycle();
        imem_ready = 1'b1;
        #1;
        check("wait3_addr", imem_addr, 32'h8);
        check("wait3_ins", InsF, mem_word(32'h8));
        check("wait3_busy", {31'd0, FetchBusy}, 32'd0);
        next_cycle();
        #1;
        check("wait_next", imem_addr, 32'hC);

        // 3: branch while waiting at address 8 -> drain, then 0x40
        next_cycle();
        do_reset();
        next_cycle();
        next_cycle();
        imem_ready = 1'b0;
        PCSrcD     = 1'b1;
        PCBranchD  = 32'h40;
        #1;
        check("br_addr0", imem_addr, 32'h8);
        check("br_busy0", {31'd0, FetchBusy}, 32'd1);
        next_cycle();
        PCSrcD = 1'b0;
        #1;
        check("drain_addr", imem_addr, 32'h8);
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_busy", {31'd0, FetchBusy}, 32'd1);
        next_cycle();
        imem_ready = 1'b1;
        #1;
        check("drain_done_addr", imem_addr, 32'h8);
        check("drain_done_ins", InsF, 32'd0);
        check("drain_done_busy", {31'd0, FetchBusy}, 32'd1);
        next_cycle();
        #1;
        check("br_target", imem_addr, 32'h40);
        check("br_target_ins", InsF, mem_word(32'h40));
        check("br_target_busy", {31'd0, FetchBusy}, 32'd0);

        // 4: jump beats branch in the same cycle
        JumpD     = 1'b1;
        PCJumpD   = 32'h100;
        PCSrcD    = 1'b1;
        PCBranchD = 32'h40;
        next_cycle();
        JumpD  = 1'b0;
        PCSrcD = 1'b0;
        #1;
        check("jmp_addr", imem_addr, 32'h100);
        check("jmp_pcp4", PCPlus4F, 32'h104);

        // 5: three stall cycles at 0x10
        next_cycle();
        do_reset();
        for (int i = 0; i < 4; i++) next_cycle();
        StallF = 1'b1;
        #1;
        check("stl1_addr", imem_addr, 32'h10);
        check("stl1_req", {31'd0, imem_req}, 32'd1);
        check("stl1_ins", InsF, mem_word(32'h10));
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            check("stl_addr", imem_addr, 32'h10);
            check("stl_ins", InsF, mem_word(32'h10));
            check("stl_busy", {31'd0, FetchBusy}, 32'd0);
`ifdef FETCH_BUF_EN
            check("stl_req", {31'd0, imem_req}, 32'd0);
`else
            check("stl_req", {31'd0, imem_req}, 32'd1);
`endif
        end
        next_cycle();
        StallF = 1'b0;
        #1;
        check("rel_stl_addr", imem_addr, 32'h10);
        check("rel_stl_ins", InsF, mem_word(32'h10));
        next_cycle();
        #1;
        check("after_stl_addr", imem_addr, 32'h14);
        check("after_stl_req", {31'd0, imem_req}, 32'd1);

        // 6: reset asserted while draining
        next_cycle();
        do_reset();
        imem_ready = 1'b0;
        JumpD      = 1'b1;
        PCJumpD    = 32'h200;
        next_cycle();
        JumpD = 1'b0;
        #1;
        check("pre_rst_drain_busy", {31'd0, FetchBusy}, 32'd1);
        check("pre_rst_drain_addr", imem_addr, 32'h0);
        do_reset();
        check("post_rst_ins", InsF, mem_word(32'h0));
        check("post_rst_busy", {31'd0, FetchBusy}, 32'd0);
        next_cycle();
        #1;
        check("post_rst_next", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
